// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package instr_loader_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF    = 8;

  // The frame LEN field carries payload byte count minus one.
  localparam int unsigned LEN_BIAS = 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

  function automatic int unsigned len_to_count(input int unsigned len_field);
    return len_field + LEN_BIAS;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Stream input and memory write port of the program loader.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
);

  logic                     s_valid;
  logic [DATA_WIDTH-1:0]    s_data;
  logic                     s_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;

  // Loader side: consumes the stream, drives the memory write port.
  modport master (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  // Environment side: stream source and instruction memory.
  modport slave (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_loader.sv
// Loads a framed byte stream (length, payload, checksum) into instruction
// memory and holds the processor in reset until a load verifies.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  instr_loader_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           cpu_rst_n
);

  // One extra bit so a full 2**ADDRESS_WIDTH payload count fits.
  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    sum_q, sum_d;
  logic                     s_ready_q, s_ready_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     cpu_rst_n_q, cpu_rst_n_d;
  logic                     accept;

  assign accept = bus.s_valid & s_ready_q;

  // Next-state, datapath and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          sum_d   = '0;
          addr_d  = '0;
        end
      end
      LEN: begin
        if (accept) begin
          cnt_d   = CNT_W'(len_to_count(32'(bus.s_data)));
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.s_data;
          addr_d      = addr_q + ADDRESS_WIDTH'(1);
          sum_d       = sum_q + bus.s_data;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (accept) begin
          if (bus.s_data == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d   = (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
    busy_d      = s_ready_d;
    cpu_rst_n_d = done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      sum_q       <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cpu_rst_n     = cpu_rst_n_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table vectors, hand sequences for
// stalls/reset/restart, and random frames against a byte-sum model.
module tb_instr_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err, cpu_rst_n;

  instr_loader_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();

  instr_loader #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    logic [31:0] pl;   // payload bytes, first stream byte in the top byte
    logic [7:0]  ck;
    logic        ok;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;
  logic [7:0] mem_img [256] = '{default: 8'h00};
  logic [7:0] exp_mem [256] = '{default: 8'h00};

  // Instruction memory: commits a write on the clock edge that ends its cycle.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem_img[bus.mem_addr] <= bus.mem_wdata;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int image_mismatches();
    int m = 0;
    for (int a = 0; a < 256; a++) if (mem_img[a] !== exp_mem[a]) m++;
    return m;
  endfunction

  // Reference: a load succeeds when the checksum equals the payload sum mod 256.
  function automatic logic model_ok(input logic [7:0] pl[$], input logic [7:0] ck);
    int s = 0;
    foreach (pl[i]) s += int'(pl[i]);
    return (s % 256) == int'(ck);
  endfunction

  function automatic int pick_gap(input int gaps[$], input int idx, input int max_gap);
    if (idx < gaps.size()) return gaps[idx];
    if (max_gap > 0) return int'($urandom_range(max_gap, 0));
    return 0;
  endfunction

  // Called at a negedge; returns at the negedge just after the byte transferred.
  task automatic send_byte(input logic [7:0] d, input int gap);
    int n = 0;
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      chk("handshake timeout s_ready", 32'(bus.s_ready), 32'd1);
      bus.s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] pl[$], input logic [7:0] ck,
                           input logic exp_ok, input int max_gap, input int gaps[$],
                           input int start_at);
    int n;
    int base;
    logic [7:0] len;
    n   = pl.size();
    len = 8'(n - 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " after start busy,ready,done,err,cpu_rst_n"},
        32'({busy, bus.s_ready, done, err, cpu_rst_n}), 32'(5'b11000));
    base = wr_total;
    send_byte(len, pick_gap(gaps, 0, max_gap));
    chk({tag, " no write for length byte"}, 32'(bus.mem_we), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " start ignored busy,done"}, 32'({busy, done}), 32'(2'b10));
      end
      send_byte(pl[i], pick_gap(gaps, i + 1, max_gap));
      chk({tag, " write we,addr,data"}, 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
          32'({1'b1, 8'(i), pl[i]}));
      exp_mem[i] = pl[i];
    end
    send_byte(ck, pick_gap(gaps, n + 1, max_gap));
    chk({tag, " result busy,ready,done,err,cpu_rst_n"},
        32'({busy, bus.s_ready, done, err, cpu_rst_n}),
        32'({2'b00, exp_ok, ~exp_ok, exp_ok}));
    repeat (3) @(negedge clk);
    chk({tag, " write count"}, 32'(wr_total - base), 32'(n));
    chk({tag, " memory image mismatches"}, 32'(image_mismatches()), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         no_gaps[$];
    int         stall_gaps[$];
    logic [7:0] pl[$];
    logic [7:0] ck;
    vec_t       vecs[6];

    vecs[0] = '{8'h03, 32'h1305_5000, 8'h68, 1'b1};
    vecs[1] = '{8'h01, 32'hAA55_0000, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 32'h7F00_0000, 8'h7F, 1'b1};
    vecs[3] = '{8'h00, 32'h8000_0000, 8'h81, 1'b0};
    vecs[4] = '{8'h02, 32'hFFFF_0300, 8'h01, 1'b1};
    vecs[5] = '{8'h03, 32'h0102_0304, 8'h0A, 1'b1};

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset ready,we,addr,wdata,busy,done,err,cpu_rst_n",
        32'({bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done, err, cpu_rst_n}),
        32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start with s_valid high in IDLE: byte 02 must not be taken as the length
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle start+valid busy,ready,we", 32'({busy, bus.s_ready, bus.mem_we}), 32'(3'b110));
    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    chk("idle start+valid write", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, 8'h00, 8'h5A}));
    exp_mem[0] = 8'h5A;
    send_byte(8'h5A, 0);
    chk("idle start+valid result done,err", 32'({done, err}), 32'(2'b10));

    // basic 4-byte load and big-endian word view
    pl = '{8'h13, 8'h05, 8'h50, 8'h00};
    run_frame("basic", pl, 8'h68, 1'b1, 0, no_gaps, -1);
    chk("word0 big-endian", {mem_img[0], mem_img[1], mem_img[2], mem_img[3]}, 32'h1305_5000);

    pl = '{8'hAA, 8'h55};
    run_frame("bad checksum", pl, 8'h00, 1'b0, 0, no_gaps, -1);

    for (int v = 0; v < 6; v++) begin
      pl = {};
      for (int j = 0; j <= int'(vecs[v].len); j++) pl.push_back(vecs[v].pl[31 - 8*j -: 8]);
      run_frame($sformatf("vec%0d", v), pl, vecs[v].ck, vecs[v].ok, 1, no_gaps, -1);
    end

    pl = {};
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_frame("full size", pl, 8'h80, 1'b1, 0, no_gaps, -1);

    // s_valid 1-0-0-1 inside DATA
    stall_gaps = '{0, 0, 2};
    pl = '{8'h13, 8'h05, 8'h50, 8'h00};
    run_frame("stalled", pl, 8'h68, 1'b1, 0, stall_gaps, -1);

    // spurious start mid-DATA, then a reload from DONE
    run_frame("start mid-data", pl, 8'h68, 1'b1, 0, no_gaps, 2);
    chk("before reload cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    run_frame("reload", pl, 8'h68, 1'b1, 0, no_gaps, -1);

    // reset after 2 of 4 payload bytes: second write is still pending and dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    exp_mem[0] = 8'h11;
    #2 rst_n = 1'b0;
    #1;
    chk("mid-load reset outputs",
        32'({bus.s_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done, err, cpu_rst_n}),
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after reset idle busy,ready", 32'({busy, bus.s_ready}), 32'd0);
    chk("partial memory kept", 32'(image_mismatches()), 32'd0);
    run_frame("after reset", pl, 8'h68, 1'b1, 0, no_gaps, -1);

    // random frames against the byte-sum model
    for (int r = 0; r < 16; r++) begin
      int n;
      n  = int'($urandom_range(24, 1));
      pl = {};
      for (int j = 0; j < n; j++) pl.push_back(8'($urandom));
      ck = 8'($urandom);
      if ($urandom_range(3, 0) != 0) begin
        int s = 0;
        foreach (pl[j]) s += int'(pl[j]);
        ck = 8'(s % 256);
      end
      run_frame($sformatf("rand%0d", r), pl, ck, model_ok(pl, ck), 2, no_gaps, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream program loader: the write side of the byte-addressed instruction memory. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and writes payload bytes one per cycle into consecutive memory addresses starting at 0. The processor is held in reset until a load completes with a correct checksum. Bytes are written in stream order, so the first stream byte of each instruction lands at the lowest address, which is the instruction's MSB when the memory reads four bytes big-endian.

## Interface
- ADDRESS_WIDTH, 8, memory address width; maximum payload is 2**ADDRESS_WIDTH bytes
- DATA_WIDTH, 8, byte width; stream and write data width

- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load
- s_valid  input  1  stream byte valid
- s_data  input  DATA_WIDTH  stream byte
- s_ready  output  1  loader accepts byte this cycle
- mem_we  output  1  memory byte write enable
- mem_addr  output  ADDRESS_WIDTH  write address
- mem_wdata  output  DATA_WIDTH  write byte
- busy  output  1  load in progress
- done  output  1  last load succeeded (sticky)
- err  output  1  last load failed checksum (sticky)
- cpu_rst_n  output  1  processor reset, low unless done

## Operation
- States: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE/DONE/ERR: s_ready=0. A start pulse goes to LEN and clears done, err, the checksum accumulator, and the address counter. start is ignored in LEN, DATA and CHK.
- LEN: s_ready=1. The accepted byte L sets the remaining count to L+1 (1..256 bytes), then the state goes to DATA.
- DATA: s_ready=1. Each accepted byte is written to the current address, added to an 8-bit checksum (mod 2**DATA_WIDTH), and the address increments. After L+1 bytes the state goes to CHK.
- CHK: s_ready=1. If the accepted byte equals the accumulated sum, go to DONE (done=1). Otherwise go to ERR (err=1).
- Handshake: a byte transfers only in a cycle where s_valid and s_ready are both high. s_valid low stalls the FSM indefinitely without timeout.
- Address arithmetic: ADDRESS_WIDTH bits. With L=255 the final write is at address 255 and the counter wraps to 0 unused. No write ever targets an address at or above L+1.
- Memory contents are not rolled back on ERR.
- cpu_rst_n = done (registered). It deasserts only in DONE and reasserts immediately on a new start.
- busy = 1 in LEN, DATA and CHK.

## Timing
- Reset values: state IDLE; s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst_n=0.
- All outputs are registered. s_ready is a function of registered state only.
- start in cycle t: busy=1 and s_ready=1 in t+1.
- Write latency: a byte accepted in cycle t gives mem_we=1 with its mem_addr and mem_wdata in t+1, for exactly one cycle per byte. Back-to-back bytes give continuous writes.
- Checksum byte accepted in cycle t: done or err =1 and busy=0 in t+1; cpu_rst_n=1 in t+1 on success.
- Reset asserted mid-load: immediate return to reset values. A pending write is dropped and partial memory contents remain.
- Simultaneous start and s_valid in IDLE: the byte is not accepted (s_ready=0 that cycle).

## Structure
- Package instr_loader_pkg: state enum type, the default ADDRESS_WIDTH and DATA_WIDTH constants, and the frame field encoding (LEN = count-1).
- Single module. The FSM, address counter, remaining-count register and checksum accumulator are all in-line, with no sub-module. The instruction memory gains a write port driven by mem_we, mem_addr and mem_wdata.

## Test plan
- Reset then 4-byte load: start, stream 03, 13 05 50 00, checksum 68 -> writes at addresses 0..3 with those bytes, done=1, err=0, cpu_rst_n=1; the memory reads word 0x13055000 at address 0.
- Bad checksum: start, 01, AA 55, checksum 00 (expected FF) -> two writes, err=1, done=0, cpu_rst_n=0.
- Full-size load: L=FF, 256 bytes of value i at address i, checksum 80 -> last write at address FF, no write after it, done=1.
- Stalls: s_valid toggled 1-0-0-1 during DATA -> one write per accepted byte only, addresses contiguous, final result identical to the unstalled run.
- Start while busy and a reload: a start pulse mid-DATA is ignored; after DONE, a new start drops cpu_rst_n to 0 and clears done in the next cycle.
- Reset mid-load: rst_n low after 2 of 4 payload bytes -> all outputs at reset values, state IDLE, and the next full load succeeds.
